// File: rtl/system_types_pkg.sv
// Shared L1/L2 block geometry and the icache miss-queue entry type.
package system_types_pkg;

    localparam int L1_BLOCK_ADDR_WIDTH = 29;
    localparam int L1_BLOCK_SIZE_BITS  = 256;

    typedef logic [L1_BLOCK_ADDR_WIDTH-1:0] pa29_t;
    typedef logic [L1_BLOCK_SIZE_BITS-1:0]  blk256_t;

    typedef struct packed {
        logic  valid;
        logic  issued;
        logic  stale;
        pa29_t PA29;
    } icache_l2_port_entry_t;

endpackage

// File: rtl/icache_l2_port_if.sv
// icache <-> L2 miss, fill, snoop and L2-pipeline signal bundle.
interface icache_l2_port_if;
    import system_types_pkg::*;

    logic    l2_req_valid;
    pa29_t   l2_req_PA29;
    logic    l2_req_ready;
    logic    l2_resp_valid;
    pa29_t   l2_resp_PA29;
    blk256_t l2_resp_data256;
    logic    l2_snoop_inv_valid;
    pa29_t   l2_snoop_inv_PA29;
    logic    mem_req_valid;
    pa29_t   mem_req_PA29;
    logic    mem_req_ready;
    logic    mem_resp_valid;
    pa29_t   mem_resp_PA29;
    blk256_t mem_resp_data256;
    logic    coh_inv_valid;
    pa29_t   coh_inv_PA29;

    modport slave (
        input  l2_req_valid, l2_req_PA29,
        output l2_req_ready,
        output l2_resp_valid, l2_resp_PA29, l2_resp_data256,
        output l2_snoop_inv_valid, l2_snoop_inv_PA29,
        output mem_req_valid, mem_req_PA29,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_PA29, mem_resp_data256,
        input  coh_inv_valid, coh_inv_PA29
    );

    modport master (
        output l2_req_valid, l2_req_PA29,
        input  l2_req_ready,
        input  l2_resp_valid, l2_resp_PA29, l2_resp_data256,
        input  l2_snoop_inv_valid, l2_snoop_inv_PA29,
        input  mem_req_valid, mem_req_PA29,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_PA29, mem_resp_data256,
        output coh_inv_valid, coh_inv_PA29
    );

endinterface

// File: rtl/icache_l2_port_cam.sv
// Parallel block-address compare across all valid queue entries.
module icache_l2_port_cam
    import system_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  icache_l2_port_entry_t ents [DEPTH],
    input  pa29_t                 pa,
    output logic [DEPTH-1:0]      match
);

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = ents[i].valid && (ents[i].PA29 == pa);
        end
    end

endmodule

// File: rtl/icache_l2_port.sv
// L2-side icache miss responder: in-order queue, refetch on invalidate.
// ICACHE_L2_PORT_COALESCE_EN: drop requests matching a pending entry.
module icache_l2_port
    import system_types_pkg::*;
#(
    parameter int REQ_QUEUE_DEPTH       = 4,
    parameter int REQ_QUEUE_INDEX_WIDTH = $clog2(REQ_QUEUE_DEPTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    icache_l2_port_if.slave  bus
);

    localparam int IW = REQ_QUEUE_INDEX_WIDTH;
    typedef logic [IW-1:0] idx_t;
    typedef logic [IW:0]   cnt_t;

    icache_l2_port_entry_t ent_q [REQ_QUEUE_DEPTH];
    icache_l2_port_entry_t ent_d [REQ_QUEUE_DEPTH];
    icache_l2_port_entry_t head_ent;
    icache_l2_port_entry_t issue_ent;

    idx_t    head_q, head_d, issue_q, issue_d;
    idx_t    tail_q, tail_d;
    cnt_t    count_q, count_d;
    logic    resp_valid_q, resp_valid_d;
    pa29_t   resp_pa_q, resp_pa_d;
    blk256_t resp_data_q, resp_data_d;
    logic    snp_valid_q, snp_valid_d;
    pa29_t   snp_pa_q, snp_pa_d;

    logic    full, deq, refetch, acc;
    logic    enq, wr, fire, coal_hit;
    pa29_t   wr_pa;
    logic [REQ_QUEUE_DEPTH-1:0] inv_match;

    icache_l2_port_cam #(.DEPTH(REQ_QUEUE_DEPTH)) u_inv_cam (
        .ents  (ent_q),
        .pa    (bus.coh_inv_PA29),
        .match (inv_match)
    );

`ifdef ICACHE_L2_PORT_COALESCE_EN
    logic [REQ_QUEUE_DEPTH-1:0] req_match;

    icache_l2_port_cam #(.DEPTH(REQ_QUEUE_DEPTH)) u_req_cam (
        .ents  (ent_q),
        .pa    (bus.l2_req_PA29),
        .match (req_match)
    );

    // Refetch blocks acceptance, so only live entries can coalesce.
    assign coal_hit = |req_match;
`else
    assign coal_hit = 1'b0;
`endif

    assign head_ent  = ent_q[head_q];
    assign issue_ent = ent_q[issue_q];

    assign full    = (count_q == cnt_t'(REQ_QUEUE_DEPTH));
    assign deq     = bus.mem_resp_valid && (count_q != '0);
    // A same-cycle invalidate of the head counts as stale.
    assign refetch = deq && (head_ent.stale ||
                     (bus.coh_inv_valid &&
                      bus.coh_inv_PA29 == head_ent.PA29));

    assign bus.l2_req_ready  = !full && !refetch;
    assign acc   = bus.l2_req_valid && bus.l2_req_ready;
    assign enq   = acc && !coal_hit;
    assign wr    = enq || refetch;
    assign wr_pa = refetch ? head_ent.PA29 : bus.l2_req_PA29;

    assign bus.mem_req_valid = issue_ent.valid && !issue_ent.issued;
    assign bus.mem_req_PA29  = issue_ent.PA29;
    assign fire = bus.mem_req_valid && bus.mem_req_ready;

    assign bus.l2_resp_valid      = resp_valid_q;
    assign bus.l2_resp_PA29       = resp_pa_q;
    assign bus.l2_resp_data256    = resp_data_q;
    assign bus.l2_snoop_inv_valid = snp_valid_q;
    assign bus.l2_snoop_inv_PA29  = snp_pa_q;

    always_comb begin
        ent_d = ent_q;
        if (fire) begin
            ent_d[issue_q].issued = 1'b1;
        end
        // An entry issuing this cycle is conservatively marked too.
        for (int i = 0; i < REQ_QUEUE_DEPTH; i++) begin
            if (bus.coh_inv_valid && inv_match[i] && ent_d[i].issued) begin
                ent_d[i].stale = 1'b1;
            end
        end
        if (deq) begin
            ent_d[head_q].valid = 1'b0;
        end
        if (wr) begin
            ent_d[tail_q].valid  = 1'b1;
            ent_d[tail_q].issued = 1'b0;
            ent_d[tail_q].stale  = 1'b0;
            ent_d[tail_q].PA29   = wr_pa;
        end
    end

    always_comb begin
        head_d  = head_q + idx_t'(deq);
        tail_d  = tail_q + idx_t'(wr);
        issue_d = issue_q + idx_t'(fire);
        count_d = count_q + cnt_t'(wr) - cnt_t'(deq);
    end

    always_comb begin
        resp_valid_d = deq && !refetch;
        resp_pa_d    = resp_pa_q;
        resp_data_d  = resp_data_q;
        if (resp_valid_d) begin
            resp_pa_d   = head_ent.PA29;
            resp_data_d = bus.mem_resp_data256;
        end
        snp_valid_d = bus.coh_inv_valid;
        snp_pa_d    = bus.coh_inv_valid ? bus.coh_inv_PA29 : snp_pa_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < REQ_QUEUE_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q       <= '0;
            issue_q      <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_pa_q    <= '0;
            resp_data_q  <= '0;
            snp_valid_q  <= 1'b0;
            snp_pa_q     <= '0;
        end else begin
            ent_q        <= ent_d;
            head_q       <= head_d;
            issue_q      <= issue_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_pa_q    <= resp_pa_d;
            resp_data_q  <= resp_data_d;
            snp_valid_q  <= snp_valid_d;
            snp_pa_q     <= snp_pa_d;
        end
    end

    resp_order_a: assert property (
        @(posedge CLK) disable iff (!nRST)
        bus.mem_resp_valid |->
            (count_q != '0 && bus.mem_resp_PA29 == head_ent.PA29)
    );

endmodule
